// File: rtl/z16_dmem_arbiter_if.sv
// Bundle of the two requester ports and the data memory port of the Z16 data memory arbiter.
interface z16_dmem_arbiter_if #(
    parameter int P_AW = 16,
    parameter int P_DW = 16
);
    logic            i_req0;
    logic            i_req1;
    logic            i_we0;
    logic            i_we1;
    logic [P_AW-1:0] i_addr0;
    logic [P_AW-1:0] i_addr1;
    logic [P_DW-1:0] i_wdata0;
    logic [P_DW-1:0] i_wdata1;
    logic            o_gnt0;
    logic            o_gnt1;
    logic            o_rvalid0;
    logic            o_rvalid1;
    logic [P_DW-1:0] o_rdata0;
    logic [P_DW-1:0] o_rdata1;
    logic [P_AW-1:0] o_mem_addr;
    logic            o_mem_wen;
    logic [P_DW-1:0] o_mem_wdata;
    logic [P_DW-1:0] i_mem_rdata;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
        input  i_mem_rdata,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        output o_mem_addr, o_mem_wen, o_mem_wdata
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
        output i_mem_rdata,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        input  o_mem_addr, o_mem_wen, o_mem_wdata
    );
endinterface

// File: rtl/z16_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port Z16 data memory between the CPU
// load/store port (0) and the loader/debug port (1).
module z16_dmem_arb_rport #(
    parameter int P_DW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            ld,
    input  logic [P_DW-1:0] d,
    output logic            rvalid,
    output logic [P_DW-1:0] rdata
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= ld;
            if (ld) rdata <= d;
        end
    end
endmodule

module z16_dmem_arbiter #(
    parameter int P_AW      = 16,
    parameter int P_DW      = 16,
    parameter int P_MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    z16_dmem_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_M1 = 4'(P_MEM_LAT - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          state;
    logic            rr_ptr;
    logic [3:0]      lat_cnt;
    logic            cap_owner;
    logic            cap_we;
    logic [P_AW-1:0] cap_addr;
    logic [P_DW-1:0] cap_wdata;

    logic [1:0]            req, we, gnt, rd_ld, rvalid;
    logic [1:0][P_AW-1:0]  addr;
    logic [1:0][P_DW-1:0]  wdata, rdata;
    logic                  win, last;

    assign req   = {bus.i_req1, bus.i_req0};
    assign we    = {bus.i_we1, bus.i_we0};
    assign addr  = {bus.i_addr1, bus.i_addr0};
    assign wdata = {bus.i_wdata1, bus.i_wdata0};

    // Grant is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE && i_rst_n) begin
            if (req[0] && (!req[1] || !rr_ptr)) gnt[0] = 1'b1;
            else if (req[1])                    gnt[1] = 1'b1;
        end
    end

    assign win  = gnt[1];
    assign last = (state == ACCESS) && (lat_cnt == 4'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lat_cnt   <= 4'd0;
            cap_owner <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        cap_owner <= win;
                        cap_we    <= we[win];
                        cap_addr  <= addr[win];
                        cap_wdata <= wdata[win];
                        rr_ptr    <= ~win;
                        lat_cnt   <= LAT_M1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                    else                 state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is sampled on the final access cycle and presented one cycle later.
    assign rd_ld = (last && !cap_we) ? (cap_owner ? 2'b10 : 2'b01) : 2'b00;

    for (genvar g = 0; g < 2; g++) begin : g_port
        z16_dmem_arb_rport #(.P_DW(P_DW)) u_rport (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .ld      (rd_ld[g]),
            .d       (bus.i_mem_rdata),
            .rvalid  (rvalid[g]),
            .rdata   (rdata[g])
        );
    end

    assign bus.o_gnt0      = gnt[0];
    assign bus.o_gnt1      = gnt[1];
    assign bus.o_rvalid0   = rvalid[0];
    assign bus.o_rvalid1   = rvalid[1];
    assign bus.o_rdata0    = rdata[0];
    assign bus.o_rdata1    = rdata[1];
    assign bus.o_mem_addr  = (state == ACCESS) ? cap_addr  : '0;
    assign bus.o_mem_wdata = (state == ACCESS) ? cap_wdata : '0;
    assign bus.o_mem_wen   = last && cap_we;
endmodule
